// File: rtl/fifo_2.sv
// Single-clock FIFO with a global enable, a registered read port and occupancy-based flags.
// Storage is a plain array with no reset, so it can map onto block RAM.
module fifo_2 #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_on,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH:0]   count_next;
  logic [DATA_WIDTH-1:0] dout_reg;
  logic                  rd_accept;
  logic                  wr_accept;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_COUNT);
  assign dout  = dout_reg;

  // A read on a full FIFO frees a slot, so a simultaneous write is still taken.
  assign rd_accept = fifo_on & rd_en & ~empty;
  assign wr_accept = fifo_on & wr_en & (~full | rd_accept);

  always_comb begin
    count_next = count_reg;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + (ADDR_WIDTH + 1)'(1);
      2'b01:   count_next = count_reg - (ADDR_WIDTH + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage write; suppressed while reset is held so the array is frozen too.
  always_ff @(posedge clk) begin
    if (wr_accept && !rst) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
      end
      if (rd_accept) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_WIDTH'(1);
        dout_reg   <= mem[rd_ptr_reg];
      end
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_fifo_2.sv
// Directed self-checking bench for fifo_2: reset, streaming, full/empty limits,
// simultaneous access, enable freeze and asynchronous reset.
module tb_fifo_2;

  logic        clk;
  logic        rst;
  logic        fifo_on;
  logic [31:0] din;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] dout;
  logic        empty;
  logic        full;

  int checks = 0;
  int errors = 0;

  fifo_2 dut (
    .clk    (clk),
    .rst    (rst),
    .fifo_on(fifo_on),
    .din    (din),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .dout   (dout),
    .empty  (empty),
    .full   (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t on=%b wr=%b rd=%b din=%h dout=%h empty=%b full=%b",
             $time, fifo_on, wr_en, rd_en, din, dout, empty, full);
  endtask

  initial begin
    rst = 1'b1; fifo_on = 1'b0; din = '0; wr_en = 1'b0; rd_en = 1'b0;

    // 1: reset held with the block disabled
    for (int i = 0; i < 9; i++) begin
      step();
      chk("rst_dout", dout, 32'h0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
    end
    fifo_on = 1'b1;
    rst = 1'b0;
    step();
    chk("post_rst_empty", 32'(empty), 32'd1);
    chk("post_rst_dout", dout, 32'h0);

    // 2: write 0..5 then read for 17 clocks
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = 32'(i);
      step();
      chk("s2_wr_empty", 32'(empty), 32'd0);
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step();
      chk("s2_rd_dout", dout, (k < 6) ? 32'(k) : 32'd5);
      chk("s2_rd_empty", 32'(empty), (k >= 5) ? 32'd1 : 32'd0);
    end
    rd_en = 1'b0;

    // 3: fill to DEPTH, drop one extra write, drain
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = 32'hA0 + 32'(i);
      step();
      chk("s3_fill_full", 32'(full), (i == 15) ? 32'd1 : 32'd0);
    end
    din = 32'hDEAD;
    step();
    chk("s3_drop_full", 32'(full), 32'd1);
    chk("s3_drop_dout", dout, 32'd5);
    wr_en = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("s3_drain_dout", dout, 32'hA0 + 32'(i));
      chk("s3_drain_full", 32'(full), 32'd0);
      chk("s3_drain_empty", 32'(empty), (i == 15) ? 32'd1 : 32'd0);
    end
    step();
    chk("s3_extra_rd_dout", dout, 32'hAF);

    // 4: three queued, then four clocks of simultaneous read and write
    rd_en = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 32'h10 + 32'(i);
      step();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 32'h20 + 32'(i);
      step();
      chk("s4_rw_dout", dout, (i < 3) ? 32'h10 + 32'(i) : 32'h20);
      chk("s4_rw_empty", 32'(empty), 32'd0);
      chk("s4_rw_full", 32'(full), 32'd0);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s4_tail_dout", dout, 32'h21 + 32'(i));
      chk("s4_tail_empty", 32'(empty), (i == 2) ? 32'd1 : 32'd0);
    end
    rd_en = 1'b0;

    // 5: freeze with fifo_on=0 while toggling requests
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 32'h30 + 32'(i);
      step();
    end
    wr_en = 1'b0;
    fifo_on = 1'b0;
    din = 32'hFF;
    for (int i = 0; i < 5; i++) begin
      wr_en = i[0];
      rd_en = ~i[0];
      step();
      chk("s5_frz_dout", dout, 32'h23);
      chk("s5_frz_empty", 32'(empty), 32'd0);
      chk("s5_frz_full", 32'(full), 32'd0);
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    fifo_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s5_drain_dout", dout, 32'h30 + 32'(i));
      chk("s5_drain_empty", 32'(empty), (i == 4) ? 32'd1 : 32'd0);
    end
    rd_en = 1'b0;

    // 6: asynchronous reset pulse with four entries held
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 32'h40 + 32'(i);
      step();
    end
    wr_en = 1'b0;
    chk("s6_pre_empty", 32'(empty), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("s6_async_empty", 32'(empty), 32'd1);
    chk("s6_async_full", 32'(full), 32'd0);
    chk("s6_async_dout", dout, 32'h0);
    #1 rst = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s6_ign_dout", dout, 32'h0);
      chk("s6_ign_empty", 32'(empty), 32'd1);
    end
    rd_en = 1'b0;
    wr_en = 1'b1;
    din = 32'h50;
    step();
    chk("s6_new_empty", 32'(empty), 32'd0);
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    chk("s6_new_dout", dout, 32'h50);
    chk("s6_new_drained", 32'(empty), 32'd1);
    rd_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
